// File: rtl/access_pkg.sv
// Shared types and constants for the single-port memory access multiplexer.
package access_pkg;

  localparam int unsigned NUM_MASTERS = 4;
  localparam int unsigned GRANT_W     = 2;
  localparam int unsigned DEF_ADDR_W  = 24;
  localparam int unsigned DEF_DATA_W  = 32;

  // Transfer sequencing: latch, hand to memory, await response, drop request.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  // One-hot decode of a master index.
  function automatic logic [NUM_MASTERS-1:0] onehot(input logic [GRANT_W-1:0] idx);
    return NUM_MASTERS'(1) << idx;
  endfunction

endpackage

// File: rtl/access_watchdog.sv
// Response watchdog: counts consecutive active cycles and flags the limit.
// Built only when ACCESS_MUX_TIMEOUT_EN is defined.
module access_watchdog #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active_i,
  output logic expire_c
);

  localparam int unsigned CNT_W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Fires on the LIMIT-th active cycle; the counter restarts whenever idle.
  assign expire_c = active_i && (count_q == CNT_W'(LIMIT - 1));

  // Next count: clear outside the window and on expiry, otherwise increment.
  always_comb begin
    count_d = '0;
    if (active_i && !expire_c) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/access_mux.sv
// Single-port memory access multiplexer behind a 4-way sticky round-robin
// arbiter. Latches the granted master's command, issues it to memory, returns
// a one-cycle ack and briefly drops that master's request so the arbiter moves.
// Optional response watchdog: define ACCESS_MUX_TIMEOUT_EN.
module access_mux #(
  parameter int unsigned ADDR_W         = access_pkg::DEF_ADDR_W,
  parameter int unsigned DATA_W         = access_pkg::DEF_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                                      sys_clk,
  input  logic                                      sys_rst_n,
  input  logic [access_pkg::NUM_MASTERS-1:0]        m_valid,
  input  logic [access_pkg::NUM_MASTERS-1:0]        m_we,
  input  logic [access_pkg::NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [access_pkg::NUM_MASTERS*DATA_W-1:0] m_wdata,
  output logic [access_pkg::NUM_MASTERS-1:0]        m_ack,
  output logic [access_pkg::NUM_MASTERS-1:0]        m_err,
  output logic [DATA_W-1:0]                         m_rdata,
  output logic [access_pkg::NUM_MASTERS-1:0]        arb_requests,
  input  logic [access_pkg::GRANT_W-1:0]            arb_grant,
  output logic                                      mem_cmd_valid,
  input  logic                                      mem_cmd_ready,
  output logic                                      mem_cmd_we,
  output logic [ADDR_W-1:0]                         mem_cmd_addr,
  output logic [DATA_W-1:0]                         mem_cmd_wdata,
  input  logic                                      mem_rsp_valid,
  input  logic [DATA_W-1:0]                         mem_rsp_rdata
);

  import access_pkg::*;

  state_e                   state_q, state_d;
  logic [GRANT_W-1:0]       cur_q, cur_d;
  logic                     cmd_valid_q, cmd_valid_d;
  logic                     cmd_we_q, cmd_we_d;
  logic [ADDR_W-1:0]        cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0]        cmd_wdata_q, cmd_wdata_d;
  logic [NUM_MASTERS-1:0]   ack_q, ack_d;
  logic [NUM_MASTERS-1:0]   err_q, err_d;
  logic [DATA_W-1:0]        rdata_q, rdata_d;
  logic [NUM_MASTERS-1:0]   rel_mask_c;
  logic                     expire_c;

  // A zero watchdog limit is not a usable configuration; this named block
  // makes such a build stand out in the elaborated hierarchy.
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_limit_zero
  end

`ifdef ACCESS_MUX_TIMEOUT_EN
  // Watchdog window is the WAIT state.
  access_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .active_i (state_q == ST_WAIT),
    .expire_c (expire_c)
  );
`else
  assign expire_c = 1'b0;
`endif

  // Release mask: the serviced master's request is withheld for one cycle.
  always_comb begin
    rel_mask_c = '0;
    if (state_q == ST_RELEASE) begin
      rel_mask_c = onehot(cur_q);
    end
  end

  assign arb_requests = m_valid & ~rel_mask_c;

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    cmd_valid_d = cmd_valid_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    ack_d       = ack_q;
    err_d       = err_q;
    rdata_d     = rdata_q;

    case (state_q)
      ST_IDLE: begin
        // A grant pointing at a non-requesting master is stale; wait it out.
        if (m_valid[arb_grant]) begin
          cur_d       = arb_grant;
          cmd_we_d    = m_we[arb_grant];
          cmd_addr_d  = m_addr[int'(arb_grant)*ADDR_W +: ADDR_W];
          cmd_wdata_d = m_wdata[int'(arb_grant)*DATA_W +: DATA_W];
          cmd_valid_d = 1'b1;
          state_d     = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (mem_cmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d     = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // A response in the expiry cycle still completes normally.
        if (mem_rsp_valid) begin
          rdata_d = mem_rsp_rdata;
          ack_d   = onehot(cur_q);
          err_d   = '0;
          state_d = ST_RELEASE;
        end else if (expire_c) begin
          rdata_d = '0;
          ack_d   = onehot(cur_q);
          err_d   = onehot(cur_q);
          state_d = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        ack_d   = '0;
        err_d   = '0;
        rdata_d = '0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any outstanding response.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      cur_q       <= '0;
      cmd_valid_q <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      ack_q       <= '0;
      err_q       <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
    end
  end

  assign mem_cmd_valid = cmd_valid_q;
  assign mem_cmd_we    = cmd_we_q;
  assign mem_cmd_addr  = cmd_addr_q;
  assign mem_cmd_wdata = cmd_wdata_q;
  assign m_ack         = ack_q;
  assign m_err         = err_q;
  assign m_rdata       = rdata_q;

endmodule

// File: tb/tb_access_mux.sv
// Scoreboard bench for access_mux: stimulus pushes expected commands/acks,
// a negedge monitor pops and compares them as the DUT presents them.
`timescale 1ns/1ps
module tb_access_mux;

  localparam int unsigned AW = 24;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;

  logic            sys_clk = 1'b0;
  logic            sys_rst_n = 1'b0;
  logic [3:0]      m_valid, m_we, m_ack, m_err, arb_requests;
  logic [4*AW-1:0] m_addr;
  logic [4*DW-1:0] m_wdata;
  logic [DW-1:0]   m_rdata, mem_cmd_wdata, mem_rsp_rdata;
  logic [1:0]      arb_grant;
  logic            mem_cmd_valid, mem_cmd_ready, mem_cmd_we, mem_rsp_valid;
  logic [AW-1:0]   mem_cmd_addr;

  always #5 sys_clk = ~sys_clk;

  access_mux #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .m_valid(m_valid), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata),
    .arb_requests(arb_requests), .arb_grant(arb_grant),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_we(mem_cmd_we), .mem_cmd_addr(mem_cmd_addr), .mem_cmd_wdata(mem_cmd_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata)
  );

  // Sticky round-robin arbiter model with a registered grant.
  logic [1:0] model_grant_q;
  bit         model_en = 1'b0;
  logic [1:0] forced_grant = 2'd0;

  function automatic logic [1:0] rr_next(input logic [3:0] req, input logic [1:0] g);
    logic [1:0] c;
    if (req[g]) return g;
    for (int k = 1; k < 4; k++) begin
      c = g + 2'(k);
      if (req[c]) return c;
    end
    return g;
  endfunction

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) model_grant_q <= 2'd0;
    else            model_grant_q <= rr_next(arb_requests, model_grant_q);
  end

  assign arb_grant = model_en ? model_grant_q : forced_grant;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  typedef struct {
    logic [3:0]    ack;
    logic [3:0]    err;
    logic [DW-1:0] rdata;
    int            lat;
  } ack_t;

  cmd_t cmd_q[$];
  ack_t ack_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input int val);
    checks++;
    errors++;
    $display("FAIL %s: observed %0d, required none", name, val);
  endtask

  // Memory responder: configurable ready stall and response delay.
  int            rdy_wait = 0;
  int            rsp_wait = 0;
  logic [DW-1:0] rsp_base = '0;
  int            rsp_cnt = 0;
  bit            mem_busy = 1'b0;

  initial begin
    mem_cmd_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = '0;
    forever begin
      @(posedge sys_clk); #1;
      if (sys_rst_n && mem_cmd_valid) begin
        mem_busy = 1'b1;
        repeat (rdy_wait) begin @(posedge sys_clk); #1; end
        mem_cmd_ready = 1'b1;
        @(posedge sys_clk); #1;
        mem_cmd_ready = 1'b0;
        repeat (rsp_wait) begin @(posedge sys_clk); #1; end
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = rsp_base + DW'(rsp_cnt);
        @(posedge sys_clk); #1;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = '0;
        rsp_cnt++;
        mem_busy = 1'b0;
      end
    end
  end

  // Monitor: command handshake, command stability, acks and request mask.
  initial begin
    cmd_t prev;
    cmd_t e;
    ack_t a;
    bit   pend;
    int   acc_cyc;
    pend = 1'b0;
    acc_cyc = 0;
    forever begin
      @(negedge sys_clk);
      if (!sys_rst_n) begin
        pend = 1'b0;
        continue;
      end
      if (pend) begin
        chk("cmd_hold_valid", 64'(mem_cmd_valid), 64'd1);
        chk("cmd_hold_fields", 64'({mem_cmd_we, mem_cmd_addr, mem_cmd_wdata}), 64'(prev));
      end
      if (mem_cmd_valid && mem_cmd_ready) begin
        acc_cyc = cyc;
        if (cmd_q.size() == 0) fail("cmd_unexpected", int'(mem_cmd_addr));
        else begin
          e = cmd_q.pop_front();
          chk("cmd_fields", 64'({mem_cmd_we, mem_cmd_addr, mem_cmd_wdata}), 64'(e));
        end
      end
      pend = mem_cmd_valid && !mem_cmd_ready;
      prev = {mem_cmd_we, mem_cmd_addr, mem_cmd_wdata};
      if (m_ack != 4'd0) begin
        if (ack_q.size() == 0) fail("ack_unexpected", int'(m_ack));
        else begin
          a = ack_q.pop_front();
          chk("ack_onehot", 64'(m_ack), 64'(a.ack));
          chk("ack_err", 64'(m_err), 64'(a.err));
          chk("ack_rdata", 64'(m_rdata), 64'(a.rdata));
          chk("ack_latency", 64'(cyc - acc_cyc), 64'(a.lat));
          chk("release_mask", 64'(arb_requests), 64'(m_valid & ~a.ack));
        end
      end else begin
        chk("quiet_err_rdata", 64'({m_err, m_rdata}), 64'd0);
        if (m_valid != 4'd0) chk("requests_pass", 64'(arb_requests), 64'(m_valid));
      end
    end
  end

  task automatic set_master(input int i, input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
    m_we[i] = we;
    m_addr[i*AW +: AW] = a;
    m_wdata[i*DW +: DW] = d;
  endtask

  task automatic push_txn(input int i, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] rd,
                          input int lat, input bit err);
    ack_t x;
    cmd_q.push_back({we, a, d});
    x.ack   = 4'(1) << i;
    x.err   = err ? x.ack : 4'd0;
    x.rdata = rd;
    x.lat   = lat;
    ack_q.push_back(x);
  endtask

  // Returns at #1 after the edge on which the n-th ack became visible.
  task automatic wait_acks(input int n, input int budget);
    int seen = 0;
    for (int c = 0; c < budget && seen < n; c++) begin
      @(posedge sys_clk); #1;
      if (m_ack != 4'd0) seen++;
    end
    if (seen < n) fail("ack_wait_expired", seen);
  endtask

  task automatic settle();
    int c = 0;
    repeat (3) @(posedge sys_clk);
    while (mem_busy && c < 100) begin @(posedge sys_clk); c++; end
    if (mem_busy) fail("mem_idle_wait_expired", c);
    @(posedge sys_clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed %0d cycles, required completion", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [DW-1:0] b;
    bit            found;
    m_valid = '0; m_we = '0; m_addr = '0; m_wdata = '0;

    // Reset state.
    repeat (3) @(posedge sys_clk); #1;
    chk("rst_ctrl", 64'({m_ack, m_err, mem_cmd_valid, mem_cmd_we}), 64'd0);
    chk("rst_addr", 64'(mem_cmd_addr), 64'd0);
    chk("rst_wdata", 64'(mem_cmd_wdata), 64'd0);
    chk("rst_rdata", 64'(m_rdata), 64'd0);
    @(negedge sys_clk); sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;

    // Masters 0 and 2 contend through the arbiter model: 0,2,0,2.
    model_en = 1'b1;
    rsp_base = 32'h5000_0000;
    b = rsp_base + DW'(rsp_cnt);
    set_master(0, 1'b1, 24'hA00000, 32'h0A0A_0A0A);
    set_master(2, 1'b0, 24'hA20000, 32'h2222_2222);
    push_txn(0, 1'b1, 24'hA00000, 32'h0A0A_0A0A, b,          2, 1'b0);
    push_txn(2, 1'b0, 24'hA20000, 32'h2222_2222, b + 32'd1,  2, 1'b0);
    push_txn(0, 1'b1, 24'hA00000, 32'h0A0A_0A0A, b + 32'd2,  2, 1'b0);
    push_txn(2, 1'b0, 24'hA20000, 32'h2222_2222, b + 32'd3,  2, 1'b0);
    m_valid = 4'b0101;
    wait_acks(4, 80);
    m_valid = '0;
    settle();
    model_en = 1'b0;

    // Master 1 write, response three cycles after accept.
    forced_grant = 2'd1;
    rsp_wait = 2;
    rsp_base = 32'hC0DE_0000;
    set_master(1, 1'b1, 24'h000100, 32'hDEAD_BEEF);
    push_txn(1, 1'b1, 24'h000100, 32'hDEAD_BEEF, rsp_base + DW'(rsp_cnt), 4, 1'b0);
    m_valid = 4'b0010;
    @(negedge sys_clk);
    chk("t1_cmd_not_before_edge", 64'(mem_cmd_valid), 64'd0);
    @(negedge sys_clk);
    chk("t1_cmd_next_cycle", 64'(mem_cmd_valid), 64'd1);
    wait_acks(1, 40);
    m_valid = '0;
    settle();

    // Master 2 write with ready held low for five cycles.
    forced_grant = 2'd2;
    rdy_wait = 5;
    rsp_wait = 1;
    set_master(2, 1'b1, 24'h0ABCDE, 32'h0F0F_1234);
    push_txn(2, 1'b1, 24'h0ABCDE, 32'h0F0F_1234, rsp_base + DW'(rsp_cnt), 3, 1'b0);
    m_valid = 4'b0100;
    wait_acks(1, 60);
    m_valid = '0;
    settle();
    rdy_wait = 0;

    // Master 3 read returning 0x12345678.
    forced_grant = 2'd3;
    rsp_wait = 0;
    rsp_base = 32'h1234_5678 - DW'(rsp_cnt);
    set_master(3, 1'b0, 24'h7FFFFF, 32'h0000_0000);
    push_txn(3, 1'b0, 24'h7FFFFF, 32'h0000_0000, 32'h1234_5678, 2, 1'b0);
    m_valid = 4'b1000;
    wait_acks(1, 40);
    chk("t4_rdata_with_ack", 64'(m_rdata), 64'h1234_5678);
    chk("t4_ack_master3", 64'(m_ack), 64'b1000);
    m_valid = '0;
    @(posedge sys_clk); #1;
    chk("t4_rdata_cleared", 64'(m_rdata), 64'd0);
    chk("t4_ack_cleared", 64'(m_ack), 64'd0);
    settle();

    // Stale grant, then reset in WAIT; the late response must not ack.
    forced_grant = 2'd3;
    rsp_wait = 6;
    set_master(0, 1'b0, 24'h000040, 32'h0000_0000);
    m_valid = 4'b0001;
    for (int c = 0; c < 4; c++) begin
      @(negedge sys_clk);
      chk("t5_stale_grant_idle", 64'(mem_cmd_valid), 64'd0);
    end
    cmd_q.push_back({1'b0, 24'h000040, 32'h0000_0000});
    forced_grant = 2'd0;
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge sys_clk); #2;
      if (mem_cmd_ready) begin found = 1'b1; break; end
    end
    if (!found) fail("t5_accept_wait_expired", 0);
    repeat (3) @(posedge sys_clk);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("t5_rst_ctrl", 64'({m_ack, m_err, mem_cmd_valid, mem_cmd_we}), 64'd0);
    chk("t5_rst_cmd", 64'({mem_cmd_addr, mem_cmd_wdata}), 64'd0);
    chk("t5_rst_rdata", 64'(m_rdata), 64'd0);
    m_valid = '0;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk); sys_rst_n = 1'b1;
    repeat (10) @(posedge sys_clk);
    settle();

`ifdef ACCESS_MUX_TIMEOUT_EN
    // No timely response: watchdog acks with error after TO WAIT cycles.
    forced_grant = 2'd1;
    rsp_wait = 14;
    set_master(1, 1'b1, 24'h000200, 32'h1111_2222);
    push_txn(1, 1'b1, 24'h000200, 32'h1111_2222, 32'h0, TO + 1, 1'b1);
    m_valid = 4'b0010;
    wait_acks(1, 60);
    chk("t6_timeout_err", 64'(m_err), 64'b0010);
    m_valid = '0;
    repeat (16) @(posedge sys_clk);
    settle();
`endif

    chk("sb_cmd_drained", 64'(cmd_q.size()), 64'd0);
    chk("sb_ack_drained", 64'(ack_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/access_mux.md
Name: access_mux

Overview:
- Single-port memory access multiplexer that sits directly downstream of the 4-way round-robin access arbiter.
- Drives the arbiter's request lines from the master valids and consumes its 2-bit grant index.
- Latches the granted master's command, issues it on one valid/ready memory command port and routes the response back as a one-cycle ack.
- Forces a one-cycle request release after each transfer so the sticky arbiter rotates.

Parameters:
- ADDR_W, 24, memory address width
- DATA_W, 32, data width
- TIMEOUT_CYCLES, 255, response watchdog limit in WAIT cycles; used only with ACCESS_MUX_TIMEOUT_EN

Ports:
- sys_clk  in  1  clock
- sys_rst_n  in  1  asynchronous active-low reset
- m_valid  in  4  per-master command valid; held with the command until m_ack
- m_we  in  4  per-master write enable
- m_addr  in  4*ADDR_W  per-master address; master i in bits [i*ADDR_W +: ADDR_W]
- m_wdata  in  4*DATA_W  per-master write data, packed the same way
- m_ack  out  4  one-hot, one-cycle completion pulse
- m_err  out  4  one-hot error, qualified by m_ack
- m_rdata  out  DATA_W  shared read data, valid while m_ack is nonzero
- arb_requests  out  4  to arbiter requests input
- arb_grant  in  2  from arbiter grant output; registered, one cycle behind arb_requests
- mem_cmd_valid  out  1  command valid
- mem_cmd_ready  in  1  command accept
- mem_cmd_we  out  1  write enable
- mem_cmd_addr  out  ADDR_W  address
- mem_cmd_wdata  out  DATA_W  write data
- mem_rsp_valid  in  1  response strobe; exactly one per accepted command
- mem_rsp_rdata  in  DATA_W  response data

Behaviour:
- Reset (async assert, sync deassert):
  - state IDLE, cur=0.
  - All outputs 0, including mem_cmd_* and m_ack/m_err/m_rdata.
  - Any outstanding memory response is abandoned.
- State and mask:
  - States: IDLE, ISSUE, WAIT, RELEASE.
  - cur is the 2-bit latched master index.
  - arb_requests = m_valid & ~mask. mask = onehot(cur) in RELEASE, else 0. This is the only combinational output.
- IDLE:
  - If m_valid[arb_grant]=1: cur<=arb_grant; latch that master's we/addr/wdata into mem_cmd_*; mem_cmd_valid<=1; go ISSUE.
  - If it is 0 (stale grant, arbiter still rotating): issue nothing and stay in IDLE.
- ISSUE:
  - mem_cmd_* held stable while mem_cmd_ready=0.
  - On ready: mem_cmd_valid<=0; go WAIT.
- WAIT:
  - On mem_rsp_valid: m_rdata<=mem_rsp_rdata (also for writes); m_ack<=onehot(cur); go RELEASE.
- RELEASE (exactly 1 cycle):
  - m_ack pulse is visible; arb_requests[cur] forced low so the arbiter moves to the next requester.
  - Next cycle: m_ack<=0, m_rdata<=0; go IDLE.
- Latency:
  - m_valid seen in IDLE (grant matching) -> mem_cmd_valid next cycle.
  - Response edge -> m_ack next cycle.
  - Minimum 4 cycles per transfer with ready=1 and a 0-cycle-response memory (issue, wait, release, idle).
- Masters may present a new command the cycle after m_ack.
- If cur is the sole requester, the arbiter keeps the grant and cur is serviced again from IDLE.
- mem_rsp_valid outside WAIT is ignored; no ack.
- m_valid dropping while the master is latched (protocol violation) does not abort the transfer; the ack is still issued.

Optional Feature:
- ACCESS_MUX_TIMEOUT_EN defined:
  - A counter clears on WAIT entry and increments each WAIT cycle.
  - On reaching TIMEOUT_CYCLES with no response, go RELEASE with m_ack=onehot(cur), m_err=onehot(cur), m_rdata=0.
  - A late response is then ignored because it arrives outside WAIT.
  - A response arriving in the same cycle as the count limit wins: normal ack, no error.
- Not defined:
  - No counter; WAIT is unbounded.
  - m_err is tied to 0.

Decomposition:
- Package access_pkg:
  - NUM_MASTERS=4, GRANT_W=2, default ADDR_W/DATA_W.
  - State enum (IDLE/ISSUE/WAIT/RELEASE).
  - onehot helper function for a 2-bit index.
- Sub-module access_watchdog: counter plus expire flag, instantiated only under ACCESS_MUX_TIMEOUT_EN.

Test Plan:
- Master 1 write, addr 0x000100, wdata 0xDEADBEEF, arb_grant=1, mem_cmd_ready=1, response 3 cycles after accept -> mem_cmd_valid one cycle after m_valid with matching fields; m_ack=4'b0010 for exactly one cycle after mem_rsp_valid.
- Masters 0 and 2 continuously valid, with a bench model of the arbiter -> services alternate 0,2,0,2; arb_requests[cur]=0 only in the ack cycle.
- mem_cmd_ready low 5 cycles in ISSUE -> mem_cmd_valid, addr, wdata and we all stable; no ack until ready plus response.
- Read by master 3 with mem_rsp_rdata=0x12345678 -> m_rdata=0x12345678 and m_ack=4'b1000 in the same cycle; m_rdata returns to 0 next cycle.
- arb_grant=3 with only m_valid[0]=1 -> no command until grant=0; a reset pulse during WAIT forces all outputs to 0, and a later mem_rsp_valid produces no ack.
- With ACCESS_MUX_TIMEOUT_EN, TIMEOUT_CYCLES=8, no response -> m_ack[cur] and m_err[cur] pulse after 8 WAIT cycles; a late mem_rsp_valid is ignored.
